// File: rtl/conv_loop_controller_if.sv
// conv_loop_controller_if: start/stride control, operand handshake, fetch address, MAC control and result bus of the convolution loop sequencer
//   master: drives start, conv_stride_mode, a_valid; observes everything else
//   slave : the controller side
interface conv_loop_controller_if #(
  parameter int FEATURE_MAP_WIDTH  = 16,
  parameter int FEATURE_MAP_HEIGHT = 16,
  parameter int INPUT_NB_CHANNELS  = 8,
  parameter int OUTPUT_NB_CHANNELS = 8,
  parameter int KERNEL_SIZE        = 3
);
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CIW = INPUT_NB_CHANNELS > 1 ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int COW = OUTPUT_NB_CHANNELS > 1 ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int KW  = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
  logic              start;
  logic [1:0]        conv_stride_mode;
  logic              running;
  logic              a_valid;
  logic              a_ready;
  logic signed [XW:0] fetch_x;
  logic signed [YW:0] fetch_y;
  logic [CIW-1:0]    fetch_ci;
  logic [COW-1:0]    fetch_co;
  logic [KW-1:0]     fetch_kx;
  logic [KW-1:0]     fetch_ky;
  logic              fetch_pad;
  logic              mac_clear;
  logic              mac_en;
  logic              output_valid;
  logic [XW-1:0]     output_x;
  logic [YW-1:0]     output_y;
  logic [COW-1:0]    output_ch;
  logic [31:0]       stall_cycles;
  modport master (
    output start, conv_stride_mode, a_valid,
    input  running, a_ready, fetch_x, fetch_y, fetch_ci, fetch_co, fetch_kx, fetch_ky,
           fetch_pad, mac_clear, mac_en, output_valid, output_x, output_y, output_ch, stall_cycles
  );
  modport slave (
    input  start, conv_stride_mode, a_valid,
    output running, a_ready, fetch_x, fetch_y, fetch_ci, fetch_co, fetch_kx, fetch_ky,
           fetch_pad, mac_clear, mac_en, output_valid, output_x, output_y, output_ch, stall_cycles
  );
endinterface

// File: rtl/conv_loop_controller.sv
// conv_loop_controller: walks the oy/ox/co/ci/ky/kx loop nest of one conv layer, steering operand fetch and MAC clear/enable
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset
//   bus    : conv_loop_controller_if.slave (start/stride in, handshake, fetch coords, MAC control, result strobe)
//   Optional STALL_COUNT_EN: count RUN cycles without an operand beat on stall_cycles (tied to 0 otherwise)
module conv_loop_controller #(
  parameter int FEATURE_MAP_WIDTH  = 16,
  parameter int FEATURE_MAP_HEIGHT = 16,
  parameter int INPUT_NB_CHANNELS  = 8,
  parameter int OUTPUT_NB_CHANNELS = 8,
  parameter int KERNEL_SIZE        = 3,
  parameter int MAC_LATENCY        = 1
) (
  input logic clk,
  input logic arst_n,
  conv_loop_controller_if.slave bus
);
  localparam int W   = FEATURE_MAP_WIDTH;
  localparam int H   = FEATURE_MAP_HEIGHT;
  localparam int K   = KERNEL_SIZE;
  localparam int L   = MAC_LATENCY;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int CIW = INPUT_NB_CHANNELS > 1 ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int COW = OUTPUT_NB_CHANNELS > 1 ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int KW  = K > 1 ? $clog2(K) : 1;
  localparam int DW  = L > 1 ? $clog2(L) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [1:0] sh;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [COW-1:0] co;
  logic [CIW-1:0] ci;
  logic [KW-1:0] kx, ky;
  logic [DW-1:0] dcnt;
  logic go, acc, ready, kx_l, ky_l, ci_l, co_l, ox_l, oy_l, out_done, layer_done;
  int fx, fy;
  logic [L-1:0] pv;
  logic [L-1:0][XW-1:0] px;
  logic [L-1:0][YW-1:0] py;
  logic [L-1:0][COW-1:0] pc;
  always_comb begin
    go = state == IDLE && bus.start;
    ready = state == RUN;
    acc = ready && bus.a_valid;
    kx_l = kx == KW'(K - 1);
    ky_l = ky == KW'(K - 1);
    ci_l = ci == CIW'(INPUT_NB_CHANNELS - 1);
    co_l = co == COW'(OUTPUT_NB_CHANNELS - 1);
    ox_l = ox == XW'((W >> sh) - 1);
    oy_l = oy == YW'((H >> sh) - 1);
    out_done = acc && kx_l && ky_l && ci_l;
    layer_done = out_done && co_l && ox_l && oy_l;
    fx = (int'(ox) << sh) + int'(kx) - K / 2;
    fy = (int'(oy) << sh) + int'(ky) - K / 2;
    state_nx = state == IDLE ? (go ? RUN : IDLE) :
               state == RUN  ? (layer_done ? DRAIN : RUN) :
               (dcnt == DW'(L - 1) ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) dcnt <= '0;
    else dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
  // Carry chain: each level only moves when every inner level wraps on this beat
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      {sh, ox, oy, co, ci, kx, ky} <= '0;
    end else if (go) begin
      {ox, oy, co, ci, kx, ky} <= '0;
      sh <= bus.conv_stride_mode == 2'd1 ? 2'd1 : bus.conv_stride_mode == 2'd2 ? 2'd2 : 2'd0;
    end else if (acc) begin
      kx <= kx_l ? '0 : kx + 1'b1;
      if (kx_l) ky <= ky_l ? '0 : ky + 1'b1;
      if (kx_l && ky_l) ci <= ci_l ? '0 : ci + 1'b1;
      if (kx_l && ky_l && ci_l) co <= co_l ? '0 : co + 1'b1;
      if (kx_l && ky_l && ci_l && co_l) ox <= ox_l ? '0 : ox + 1'b1;
      if (kx_l && ky_l && ci_l && co_l && ox_l) oy <= oy_l ? '0 : oy + 1'b1;
    end
  // Result coordinates ride alongside the MAC latency
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      pv <= '0;
      px <= '0;
      py <= '0;
      pc <= '0;
    end else begin
      pv[0] <= out_done;
      px[0] <= ox;
      py[0] <= oy;
      pc[0] <= co;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
        pc[i] <= pc[i-1];
      end
    end
  assign bus.running = state != IDLE;
  assign bus.a_ready = ready;
  assign bus.mac_en = acc;
  assign bus.mac_clear = ready && kx == '0 && ky == '0 && ci == '0;
  // Fetch outputs are forced to 0 outside RUN so reset/idle show all-zero outputs
  assign bus.fetch_x = ready ? (XW+1)'(fx) : '0;
  assign bus.fetch_y = ready ? (YW+1)'(fy) : '0;
  assign bus.fetch_ci = ready ? ci : '0;
  assign bus.fetch_co = ready ? co : '0;
  assign bus.fetch_kx = ready ? kx : '0;
  assign bus.fetch_ky = ready ? ky : '0;
  assign bus.fetch_pad = ready && (fx < 0 || fx >= W || fy < 0 || fy >= H);
  assign bus.output_valid = pv[L-1];
  assign bus.output_x = px[L-1];
  assign bus.output_y = py[L-1];
  assign bus.output_ch = pc[L-1];
`ifdef STALL_COUNT_EN
  logic [31:0] stall;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) stall <= '0;
    else if (go) stall <= '0;
    else if (state == RUN && !bus.a_valid && stall != '1) stall <= stall + 1'b1;
  assign bus.stall_cycles = stall;
`else
  assign bus.stall_cycles = '0;
`endif
endmodule

// File: doc/conv_loop_controller.md
# conv_loop_controller

Loop sequencer for the convolution accelerator. Accepts a `start` pulse and a stride mode, then walks the full output-pixel / output-channel / input-channel / kernel loop nest. For each accepted operand beat (`a_valid && a_ready`) it tells the feature/kernel source what to fetch and tells the MAC datapath when to clear and when to accumulate. It emits `output_valid` with the output coordinates once each accumulation completes. It sits between the top-level start/running control, the operand stream and the MAC array.

## Interface
Parameters:
- `FEATURE_MAP_WIDTH`, default 16: input map width W; must be divisible by every legal stride.
- `FEATURE_MAP_HEIGHT`, default 16: input map height H; must be divisible by every legal stride.
- `INPUT_NB_CHANNELS`, default 8: input channels CI.
- `OUTPUT_NB_CHANNELS`, default 8: output channels CO.
- `KERNEL_SIZE`, default 3: K; odd, at least 1.
- `MAC_LATENCY`, default 1: cycles from the last accepted beat to its result; at least 1.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on its rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a layer.
- `conv_stride_mode` in 2: stride select, sampled with `start`. 0 → stride 1; 1 → stride 2; 2 → stride 4; 3 → reserved, treated as stride 1.
- `running` out 1: layer in progress.
- `a_valid` in 1: operand beat (`a_input`/`b_input`) present.
- `a_ready` out 1: controller accepts the beat.
- `fetch_x` out clog2(W)+1, signed: input x of the current beat.
- `fetch_y` out clog2(H)+1, signed: input y of the current beat.
- `fetch_ci` out clog2(CI): input channel of the current beat.
- `fetch_co` out clog2(CO): output channel of the current beat.
- `fetch_kx` out clog2(K): kernel x of the current beat.
- `fetch_ky` out clog2(K): kernel y of the current beat.
- `fetch_pad` out 1: current beat lies outside the map; the source supplies zero.
- `mac_clear` out 1: current beat is the first of an output; the accumulator loads instead of adds.
- `mac_en` out 1: accumulate this cycle.
- `output_valid` out 1: one-cycle result strobe.
- `output_x` out clog2(W): output-space x of the result.
- `output_y` out clog2(H): output-space y of the result.
- `output_ch` out clog2(CO): output channel of the result.
- `stall_cycles` out 32: input-starvation count (see Configuration).

## Operation
- Loop nest, outer to inner: `oy`, `ox`, `co`, `ci`, `ky`, `kx`.
  - `ox` runs 0..W/S−1 and `oy` runs 0..H/S−1, where S is the stride.
- Beats per output: B = K·K·CI. Outputs per layer: (W/S)·(H/S)·CO.
- Fetch coordinates:
  - `fetch_x = ox·S + kx − K/2` and `fetch_y = oy·S + ky − K/2`, using integer K/2.
  - `fetch_pad` = 1 when `fetch_x` < 0, `fetch_x` ≥ W, `fetch_y` < 0 or `fetch_y` ≥ H.
- FSM states:
  - IDLE: `a_ready` = 0; `start` moves to RUN and latches S; all loop counters are zeroed.
  - RUN: `a_ready` = 1. Each accepted beat advances `kx` with carries up the nest. Acceptance of the final beat of the layer moves to DRAIN.
  - DRAIN: `a_ready` = 0 for MAC_LATENCY cycles, then IDLE.
- `running` = (state ≠ IDLE).
- `start` is ignored outside IDLE.
- `mac_en` = `a_valid` && `a_ready`.
- `mac_clear` = `a_ready` && (`kx` = `ky` = `ci` = 0). It is combinational, qualified by `mac_en` at the consumer.
- On acceptance of the last beat of an output (`kx` = K−1, `ky` = K−1, `ci` = CI−1), {`ox`, `oy`, `co`} enter a MAC_LATENCY-deep shift pipeline. The pipe's valid bit drives `output_valid`.
- Output is never back-pressured.
- Reset values: every output 0, state IDLE, counters 0, pipeline flushed. Reset mid-layer aborts with no further `output_valid` pulses.

## Timing
- `start` high at edge e → `running` and `a_ready` high from cycle e+1.
- A beat accepted at edge n that completes an output → `output_valid` high for exactly one cycle, the cycle beginning at edge n+MAC_LATENCY−1+1 (MAC_LATENCY=1: the cycle right after the accepting edge).
- Last layer beat accepted at edge n → `running` low from the cycle after the final `output_valid` pulse.
- `a_valid` low in RUN stalls all counters; fetch outputs hold.
- When S=1 and K=1, every beat completes an output, so `output_valid` may be high on consecutive cycles.

## Configuration
- `STALL_COUNT_EN`:
  - Defined: `stall_cycles` increments once per cycle with state=RUN && !`a_valid`. It clears on `start` acceptance, saturates at 2³²−1, and holds after the layer ends.
  - Undefined: `stall_cycles` is tied to 0 and no counter is synthesized.

## Test plan
- W=H=4, CI=CO=2, K=3, stride mode 0, `a_valid` held 1:
  - 576 beats accepted.
  - 32 `output_valid` pulses, the first at (x0, y0, ch0) and the last at (3, 3, 1).
  - `running` drops MAC_LATENCY+1 cycles after the last beat.
- Same config, stride mode 1 → 8 outputs and 144 beats; `output_x`/`output_y` only ever 0..1.
- Border padding: the first beat of the layer has `fetch_x` = `fetch_y` = −1 and `fetch_pad` = 1. The centre tap of output (1, 1) at stride 1 has `fetch_x` = `fetch_y` = 1 and `fetch_pad` = 0.
- `a_valid` toggling 1,0,1,0 → counters advance only on accepted beats. Output count is unchanged. With `STALL_COUNT_EN`, `stall_cycles` equals the number of low cycles.
- `start` pulsed during RUN → ignored and the layer completes normally. `conv_stride_mode`=3 → behaves as stride 1.
- `arst_n` pulsed low mid-layer (after 100 beats) → all outputs 0 immediately and no further `output_valid`. A new `start` then runs the full 576 beats.
